// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch and decode stages of the 8-bit core.
// Holds the opcode map, the instruction field positions and the fetch FSM states.
package cpu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 6;
    localparam int IMM6_MSB   = 5;
    localparam int IMM6_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Computes the PC that follows an instruction.
// A jump loads its zero-extended 6-bit immediate; every other opcode steps to pc+1, wrapping.
module fetch_next_pc
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               is_jump
);

    logic [1:0] opcode;
    logic [5:0] imm6;

    always_comb begin
        opcode  = instruction[OPCODE_MSB:OPCODE_LSB];
        imm6    = instruction[IMM6_MSB:IMM6_LSB];
        is_jump = (opcode == OP_JUMP);
        next_pc = is_jump ? ADDR_W'(imm6) : pc + ADDR_W'(1);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, reads instruction memory and holds one fetched
// instruction in a valid/ready register for decode. Resolves jumps locally.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 8,
    parameter int PROG_LEN = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  Read_Address,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Fetch_En,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Redirect_Target,
    output logic [INSTR_W-1:0] Instr_Out,
    output logic               Instr_Valid,
    input  logic               Instr_Ready,
    output logic [ADDR_W-1:0]  PC_Out,
    output logic               Halted
);

    fetch_state_e       state, state_next;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
    logic               jump_unused;
    logic               past_end;
    logic               capture;

    fetch_next_pc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_next_pc (
        .pc          (pc),
        .instruction (Instruction),
        .next_pc     (next_pc),
        .is_jump     (jump_unused)
    );

    assign Read_Address = pc;
    assign Halted       = (state == HALT);
    assign past_end     = (pc >= ADDR_W'(PROG_LEN));

    // Redirect outranks everything but reset; it also pulls the unit out of HALT.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        if (Redirect) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE: if (Fetch_En) state_next = RUN;
                RUN: begin
                    if (!Fetch_En)
                        state_next = IDLE;
                    else if (past_end)
                        state_next = HALT;
                    else if (!Instr_Valid || Instr_Ready)
                        capture = 1'b1;
                end
                HALT:    state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Output register; a consumed instruction with no replacement drops valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= '0;
            Instr_Out   <= '0;
            PC_Out      <= '0;
            Instr_Valid <= 1'b0;
        end else if (Redirect) begin
            pc          <= Redirect_Target;
            Instr_Valid <= 1'b0;
        end else if (capture) begin
            Instr_Out   <= Instruction;
            PC_Out      <= pc;
            Instr_Valid <= 1'b1;
            pc          <= next_pc;
        end else if (Instr_Ready) begin
            Instr_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small combinational instruction memory.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Read_Address;
    logic [7:0] Instruction;
    logic       Fetch_En;
    logic       Redirect;
    logic [7:0] Redirect_Target;
    logic [7:0] Instr_Out;
    logic       Instr_Valid;
    logic       Instr_Ready;
    logic [7:0] PC_Out;
    logic       Halted;

    logic [7:0] imem [0:255];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign Instruction = imem[Read_Address];

    instr_fetch_unit #(.ADDR_W(8), .INSTR_W(8), .PROG_LEN(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .Read_Address    (Read_Address),
        .Instruction     (Instruction),
        .Fetch_En        (Fetch_En),
        .Redirect        (Redirect),
        .Redirect_Target (Redirect_Target),
        .Instr_Out       (Instr_Out),
        .Instr_Valid     (Instr_Valid),
        .Instr_Ready     (Instr_Ready),
        .PC_Out          (PC_Out),
        .Halted          (Halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog(input logic [7:0] last);
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        imem[0] = 8'h44; imem[1] = 8'h49; imem[2] = 8'h18; imem[3] = 8'h89;
        imem[4] = last;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; Fetch_En = 1'b0; Redirect = 1'b0;
        Redirect_Target = 8'h00; Instr_Ready = 1'b1;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_prog(8'hC3);
        do_reset();
        checks++;
        if ({Instr_Valid, Instr_Out, PC_Out, Read_Address, Halted} !== 26'h0) begin
            errors++;
            $display("FAIL reset: valid=%b out=%h pc_out=%h addr=%h halted=%b",
                     Instr_Valid, Instr_Out, PC_Out, Read_Address, Halted);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] exp_i [0:6];
        logic [7:0] exp_p [0:6];
        exp_i = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3, 8'h89, 8'hC3};
        exp_p = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4};
        load_prog(8'hC3);
        do_reset();
        Fetch_En = 1'b1;
        step();
        checks++;
        if (Instr_Valid !== 1'b0) begin
            errors++; $display("FAIL seq_first_cycle: valid=%b want 0", Instr_Valid);
        end
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (Instr_Valid !== 1'b1 || Instr_Out !== exp_i[i] || PC_Out !== exp_p[i] || Halted !== 1'b0) begin
                errors++;
                $display("FAIL seq[%0d]: valid=%b out=%h pc_out=%h halted=%b want 1 %h %h 0",
                         i, Instr_Valid, Instr_Out, PC_Out, Halted, exp_i[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_end_of_program();
        load_prog(8'h00);
        do_reset();
        Fetch_En = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (Instr_Valid !== 1'b1 || PC_Out !== 8'(i)) begin
                errors++;
                $display("FAIL eop_fetch[%0d]: valid=%b pc_out=%h want 1 %h", i, Instr_Valid, PC_Out, 8'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (Instr_Valid !== 1'b0 || Halted !== 1'b1 || Read_Address !== 8'd5) begin
                errors++;
                $display("FAIL eop_halt[%0d]: valid=%b halted=%b addr=%h want 0 1 05",
                         i, Instr_Valid, Halted, Read_Address);
            end
        end
    endtask

    task automatic test_stall();
        load_prog(8'hC3);
        do_reset();
        Fetch_En = 1'b1;
        step();
        step(); step(); step();
        Instr_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (Instr_Valid !== 1'b1 || Instr_Out !== 8'h18 || PC_Out !== 8'd2 || Read_Address !== 8'd3) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b out=%h pc_out=%h addr=%h want 1 18 02 03",
                         i, Instr_Valid, Instr_Out, PC_Out, Read_Address);
            end
        end
        Instr_Ready = 1'b1;
        step();
        checks++;
        if (Instr_Out !== 8'h89 || PC_Out !== 8'd3) begin
            errors++; $display("FAIL stall_release1: out=%h pc_out=%h want 89 03", Instr_Out, PC_Out);
        end
        step();
        checks++;
        if (Instr_Out !== 8'hC3 || PC_Out !== 8'd4) begin
            errors++; $display("FAIL stall_release2: out=%h pc_out=%h want c3 04", Instr_Out, PC_Out);
        end
    endtask

    task automatic test_redirect();
        // Continues from test_stall: PC is 3 after the jump.
        step();
        checks++;
        if (Instr_Out !== 8'h89 || Instr_Valid !== 1'b1) begin
            errors++; $display("FAIL redir_setup: out=%h valid=%b want 89 1", Instr_Out, Instr_Valid);
        end
        Redirect = 1'b1; Redirect_Target = 8'h01;
        step();
        Redirect = 1'b0;
        checks++;
        if (Instr_Valid !== 1'b0 || Instr_Out !== 8'h89 || Read_Address !== 8'h01) begin
            errors++;
            $display("FAIL redir_flush: valid=%b out=%h addr=%h want 0 89 01", Instr_Valid, Instr_Out, Read_Address);
        end
        step();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_Out !== 8'h49 || PC_Out !== 8'd1) begin
            errors++;
            $display("FAIL redir_target: valid=%b out=%h pc_out=%h want 1 49 01", Instr_Valid, Instr_Out, PC_Out);
        end
        // Redirect out of HALT.
        load_prog(8'h00);
        do_reset();
        Fetch_En = 1'b1;
        repeat (7) step();
        checks++;
        if (Halted !== 1'b1) begin
            errors++; $display("FAIL redir_halt_setup: halted=%b want 1", Halted);
        end
        Redirect = 1'b1; Redirect_Target = 8'h00;
        step();
        Redirect = 1'b0;
        checks++;
        if (Halted !== 1'b0 || Instr_Valid !== 1'b0 || Read_Address !== 8'h00) begin
            errors++;
            $display("FAIL redir_from_halt: halted=%b valid=%b addr=%h want 0 0 00", Halted, Instr_Valid, Read_Address);
        end
        step();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_Out !== 8'h44 || PC_Out !== 8'd0) begin
            errors++;
            $display("FAIL redir_halt_fetch: valid=%b out=%h pc_out=%h want 1 44 00", Instr_Valid, Instr_Out, PC_Out);
        end
    endtask

    task automatic test_mid_reset();
        load_prog(8'hC3);
        do_reset();
        Fetch_En = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; Fetch_En = 1'b0;
        checks++;
        if ({Instr_Valid, Instr_Out, PC_Out, Read_Address, Halted} !== 26'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b out=%h pc_out=%h addr=%h halted=%b want all 0",
                     Instr_Valid, Instr_Out, PC_Out, Read_Address, Halted);
        end
        step(); step();
        checks++;
        if (Instr_Valid !== 1'b0 || Read_Address !== 8'h00) begin
            errors++; $display("FAIL reset_no_fetch: valid=%b addr=%h want 0 00", Instr_Valid, Read_Address);
        end
        Fetch_En = 1'b1;
        step(); step();
        checks++;
        if (Instr_Out !== 8'h44 || Instr_Valid !== 1'b1) begin
            errors++; $display("FAIL reset_restart: out=%h valid=%b want 44 1", Instr_Out, Instr_Valid);
        end
        // Reset pulse entirely between edges is never sampled.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step();
        checks++;
        if (Instr_Out !== 8'h49 || PC_Out !== 8'd1 || Instr_Valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_glitch: out=%h pc_out=%h valid=%b want 49 01 1", Instr_Out, PC_Out, Instr_Valid);
        end
    endtask

    task automatic test_fetch_disable();
        // Continues from test_mid_reset: Instr_Out=0x49, PC=2.
        Instr_Ready = 1'b0; Fetch_En = 1'b0;
        step();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_Out !== 8'h49 || PC_Out !== 8'd1) begin
            errors++;
            $display("FAIL disable_hold: valid=%b out=%h pc_out=%h want 1 49 01", Instr_Valid, Instr_Out, PC_Out);
        end
        Instr_Ready = 1'b1;
        step();
        checks++;
        if (Instr_Valid !== 1'b0 || Read_Address !== 8'd2) begin
            errors++; $display("FAIL disable_accept: valid=%b addr=%h want 0 02", Instr_Valid, Read_Address);
        end
        step();
        checks++;
        if (Instr_Valid !== 1'b0 || Read_Address !== 8'd2) begin
            errors++; $display("FAIL disable_frozen: valid=%b addr=%h want 0 02", Instr_Valid, Read_Address);
        end
        Fetch_En = 1'b1;
        step(); step();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_Out !== 8'h18 || PC_Out !== 8'd2) begin
            errors++;
            $display("FAIL disable_resume: valid=%b out=%h pc_out=%h want 1 18 02", Instr_Valid, Instr_Out, PC_Out);
        end
    endtask

    initial begin
        rst_n = 1'b0; Fetch_En = 1'b0; Redirect = 1'b0;
        Redirect_Target = 8'h00; Instr_Ready = 1'b1;
        #1;
        test_reset();
        test_sequence();
        test_end_of_program();
        test_stall();
        test_redirect();
        test_mid_reset();
        test_fetch_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Front end of the 8-bit microprocessor. It owns the PC, drives the instruction-memory read address, and registers the returned 8-bit instruction into a valid/ready output stage for decode. It resolves OP_JUMP (opcode 11) itself, accepts external redirects, and halts when the PC runs past the program end.

Parameters:
ADDR_W, 8, PC / read-address width
INSTR_W, 8, instruction width
PROG_LEN, 5, number of valid instruction words; a sequential PC reaching PROG_LEN halts the unit

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
Read_Address  output  ADDR_W  to instruction memory; equals PC register (combinational)
Instruction  input  INSTR_W  from instruction memory, combinational response to Read_Address
Fetch_En  input  1  run request
Redirect  input  1  PC override, e.g. from a branch or exception
Redirect_Target  input  ADDR_W  new PC when Redirect=1
Instr_Out  output  INSTR_W  registered instruction to decode
Instr_Valid  output  1  Instr_Out holds an unconsumed instruction
Instr_Ready  input  1  decode accepts Instr_Out this cycle
PC_Out  output  ADDR_W  address Instr_Out was fetched from
Halted  output  1  unit is in HALT

Behaviour:
- All state changes on the rising clk edge. rst_n is sampled only at the edge.
- Reset (rst_n=0 at an edge): PC=0, Instr_Out=0, PC_Out=0, Instr_Valid=0, Halted=0, state=IDLE. This applies from any state, mid-transfer included.
- States:
  - IDLE: no fetch. Goes to RUN on Fetch_En=1; RUN begins fetching on the following cycle.
  - RUN: fetches.
  - HALT: Halted=1, no fetch.
- Fetch condition ("capture"): state=RUN and (Instr_Valid=0 or Instr_Ready=1) and Redirect=0.
- On capture:
  - Instr_Out<=Instruction, PC_Out<=PC, Instr_Valid<=1.
  - PC<=next_pc.
- Throughput and latency: one instruction per cycle. Read_Address=PC; the instruction appears on Instr_Out one cycle later.
- next_pc:
  - If Instruction[7:6]==2'b11, next_pc = {2'b00, Instruction[5:0]} (absolute jump).
  - Otherwise next_pc = PC+1, wrapping modulo 2^ADDR_W.
- Accept without capture: Instr_Ready=1 with no capture (IDLE, HALT, or Redirect) clears Instr_Valid.
- Stall: Instr_Valid=1 and Instr_Ready=0. Instr_Out, PC_Out and PC are held, and Read_Address is stable.
- End of program: in RUN with PC>=PROG_LEN and no Redirect, go to HALT with no capture. A pending Instr_Out is still delivered. A jump target >= PROG_LEN halts on the next cycle.
- Fetch_En=0 in RUN: go to IDLE at that edge with no capture. The pending output is held until accepted.
- Redirect=1 (highest priority after reset):
  - PC<=Redirect_Target, Instr_Valid<=0 (flush), Instr_Out/PC_Out held, state<=RUN, Halted<=0.
  - Applies from IDLE and HALT as well.
  - Redirect together with Instr_Ready: the flush wins, and the pending instruction counts as consumed.
- HALT is left only by reset or Redirect. Fetch_En is ignored in HALT.

Decomposition:
- Shared package cpu_pkg:
  - OP_ADD=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_JUMP=2'b11
  - OPCODE_MSB=7, OPCODE_LSB=6, IMM6 field [5:0]
  - fetch state encoding IDLE/RUN/HALT
- One combinational sub-module, fetch_next_pc: (pc, instruction) -> next_pc. Decode reuses the same jump rule from it.

Test Plan:
Bench IMEM model: addr0=0x44, 1=0x49, 2=0x18, 3=0x89, 4=0xC3, PROG_LEN=5, Instr_Ready=1 unless noted.
1. Reset, then Fetch_En=1 -> from the second cycle after, Instr_Out = 0x44, 0x49, 0x18, 0x89, 0xC3, 0x89, 0xC3, ... and PC_Out = 0, 1, 2, 3, 4, 3, 4, ... (jump to 3 loops); Halted=0.
2. addr4 replaced by 0x00 -> after five instructions (PC_Out 0..4), Instr_Valid=0, Halted=1, Read_Address=5 held.
3. Instr_Ready=0 for 3 cycles while Instr_Out=0x18 -> Instr_Out=0x18, PC_Out=2 and Read_Address=3 hold; after release the next outputs are 0x89, then 0xC3.
4. Redirect=1 with Redirect_Target=0x01 while Instr_Valid=1 (Instr_Out=0x89) -> next cycle Instr_Valid=0; the following cycle Instr_Out=0x49, PC_Out=1. Redirect=1 to 0x00 from HALT -> Halted=0, then Instr_Out=0x44.
5. rst_n=0 for one edge while Instr_Valid=1 -> next cycle Instr_Valid=0, Instr_Out=0, PC_Out=0, Read_Address=0, no fetch until Fetch_En=1. rst_n pulsed low between edges -> no effect.
6. Fetch_En=0 with Instr_Valid=1 and Instr_Ready=0 -> Instr_Out held; once accepted Instr_Valid=0 and PC is frozen. Fetch_En=1 again -> fetching resumes at the frozen PC.
